// File: rtl/packet_sum_text.sv
// Sum-to-text formatter: converts a 16-bit unsigned sum to decimal ASCII
// (leading zeros suppressed, CR LF or LF terminated) with a serial double-dabble.
module packet_sum_text #(
  parameter bit EOL_CRLF = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        input_valid,
  output logic        input_ready,
  input  logic [15:0] input_data,
  output logic        output_valid,
  input  logic        output_ready,
  output logic [7:0]  output_data,
  output logic        output_last
);

  typedef enum logic [1:0] {IDLE, CONVERT, LOAD, EMIT} state_t;
  typedef enum logic [1:0] {TAIL_DIGIT, TAIL_CR, TAIL_LF} tail_t;

  state_t      state, state_next;
  tail_t       tail, tail_next;
  logic [15:0] bin, bin_next;
  logic [19:0] bcd, bcd_next;
  logic [3:0]  step, step_next;
  logic [2:0]  digit, digit_next;
  logic [2:0]  digit_dec;
  logic        valid_next, last_next;
  logic [7:0]  data_next;
  logic [19:0] bcd_adj;
  logic [2:0]  first_nz;

  function automatic logic [7:0] ascii(input logic [3:0] d);
    return 8'h30 + {4'h0, d};
  endfunction

  function automatic logic [3:0] digit_of(input logic [19:0] b, input logic [2:0] i);
    return b[{i, 2'b00} +: 4];
  endfunction

  // Per-digit add-3 correction and leading-digit search over the BCD register.
  always_comb begin
    bcd_adj  = bcd;
    first_nz = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      if (bcd[4*i +: 4] != '0) first_nz = 3'(i);
    end
  end

  assign digit_dec = digit - 3'd1;

  always_comb begin
    state_next  = state;
    tail_next   = tail;
    bin_next    = bin;
    bcd_next    = bcd;
    step_next   = step;
    digit_next  = digit;
    valid_next  = output_valid;
    data_next   = output_data;
    last_next   = output_last;
    input_ready = 1'b0;
    case (state)
      IDLE: begin
        input_ready = !reset;
        if (input_valid) begin
          bin_next   = input_data;
          bcd_next   = '0;
          step_next  = '0;
          state_next = CONVERT;
        end
      end
      CONVERT: begin
        {bcd_next, bin_next} = {bcd_adj, bin} << 1;
        step_next = step + 4'd1;
        if (step == 4'd15) state_next = LOAD;
      end
      LOAD: begin
        digit_next = first_nz;
        tail_next  = TAIL_DIGIT;
        data_next  = ascii(digit_of(bcd, first_nz));
        valid_next = 1'b1;
        last_next  = 1'b0;
        state_next = EMIT;
      end
      EMIT: begin
        if (output_ready) begin
          case (tail)
            TAIL_DIGIT: begin
              if (digit != '0) begin
                digit_next = digit_dec;
                data_next  = ascii(digit_of(bcd, digit_dec));
              end else if (EOL_CRLF) begin
                tail_next = TAIL_CR;
                data_next = 8'h0D;
              end else begin
                tail_next = TAIL_LF;
                data_next = 8'h0A;
                last_next = 1'b1;
              end
            end
            TAIL_CR: begin
              tail_next = TAIL_LF;
              data_next = 8'h0A;
              last_next = 1'b1;
            end
            default: begin
              valid_next = 1'b0;
              last_next  = 1'b0;
              state_next = IDLE;
            end
          endcase
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      tail         <= TAIL_DIGIT;
      bin          <= '0;
      bcd          <= '0;
      step         <= '0;
      digit        <= '0;
      output_valid <= 1'b0;
      output_data  <= 8'h00;
      output_last  <= 1'b0;
    end else begin
      state        <= state_next;
      tail         <= tail_next;
      bin          <= bin_next;
      bcd          <= bcd_next;
      step         <= step_next;
      digit        <= digit_next;
      output_valid <= valid_next;
      output_data  <= data_next;
      output_last  <= last_next;
    end
  end

endmodule

// File: tb/tb_packet_sum_text.sv
// Self-checking bench for packet_sum_text: expected lines come from $sformatf
// decimal formatting plus the configured terminator.
module tb_packet_sum_text;

  logic        clock = 1'b0;
  logic        reset;
  logic        valid_a, valid_b;
  logic [15:0] in_data;
  logic        ready_a, ready_b;
  logic        ov_a, ov_b, out_ready;
  logic [7:0]  od_a, od_b;
  logic        ol_a, ol_b;

  always #5 clock = ~clock;

  packet_sum_text #(.EOL_CRLF(1'b1)) dut_crlf (
    .clock(clock), .reset(reset),
    .input_valid(valid_a), .input_ready(ready_a), .input_data(in_data),
    .output_valid(ov_a), .output_ready(out_ready), .output_data(od_a), .output_last(ol_a)
  );

  packet_sum_text #(.EOL_CRLF(1'b0)) dut_lf (
    .clock(clock), .reset(reset),
    .input_valid(valid_b), .input_ready(ready_b), .input_data(in_data),
    .output_valid(ov_b), .output_ready(out_ready), .output_data(od_b), .output_last(ol_b)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] got_d[$];
  logic       got_l[$];
  logic [7:0] exp_q[$];
  int         stall_err;
  int         rdy_seen;
  bit         timed_out;

  function automatic void model(input int v, input bit crlf);
    string s;
    exp_q.delete();
    s = $sformatf("%0d", v);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(8'(s[i]));
    if (crlf) exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input bit sel, input logic [15:0] v, output bit ok);
    logic r;
    ok = 1'b0;
    in_data = v;
    if (sel) valid_b = 1'b1; else valid_a = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      r = sel ? ready_b : ready_a;
      tick();
      if (r) ok = 1'b1;
    end
    valid_a = 1'b0;
    valid_b = 1'b0;
  endtask

  // Drives output_ready with the given acceptance percentage and records every handshaken byte.
  task automatic collect(input bit sel, input int pct, input int max_bytes, input int budget);
    logic v, l, pv, pr, pl;
    logic [7:0] d, pd;
    got_d.delete();
    got_l.delete();
    stall_err = 0;
    rdy_seen  = 0;
    timed_out = 1'b1;
    pv = 1'b0; pr = 1'b1; pd = '0; pl = 1'b0;
    for (int c = 0; c < budget; c++) begin
      v = sel ? ov_b : ov_a;
      d = sel ? od_b : od_a;
      l = sel ? ol_b : ol_a;
      if (sel ? ready_b : ready_a) rdy_seen++;
      if (pv && !pr && (!v || d !== pd || l !== pl)) stall_err++;
      out_ready = ($urandom_range(99) < pct);
      if (!valid_a && !valid_b) in_data = 16'($urandom);
      pv = v; pd = d; pl = l; pr = out_ready;
      tick();
      if (v && pr) begin
        got_d.push_back(d);
        got_l.push_back(l);
        if (l || got_d.size() == max_bytes) begin
          timed_out = 1'b0;
          break;
        end
      end
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; valid_a = 1'b0; valid_b = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({ov_a, od_a, ol_a, ready_a} !== 11'h000) begin
      n_err++; $display("FAIL reset_outputs: got v=%0b d=%h l=%0b rdy=%0b want 0/00/0/0", ov_a, od_a, ol_a, ready_a);
    end
    reset = 1'b0;
    tick();
    n_cmp++;
    if (ready_a !== 1'b1 || ov_a !== 1'b0) begin
      n_err++; $display("FAIL reset_release: got rdy=%0b v=%0b want 1/0", ready_a, ov_a);
    end
  endtask

  task automatic test_zero();
    bit ok;
    int first;
    model(0, 1'b1);
    out_ready = 1'b0;
    send(1'b0, 16'd0, ok);
    first = -1;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (ov_a) begin first = n; break; end
    end
    n_cmp++;
    if (!ok || first != 17) begin
      n_err++; $display("FAIL zero_latency: got accept=%0b first_valid=%0d want 1/17", ok, first);
    end
    collect(1'b0, 100, 0, 40);
    n_cmp++;
    if (timed_out || got_d.size() != exp_q.size()) begin
      n_err++; $display("FAIL zero_len: got %0d bytes timeout=%0b want %0d", got_d.size(), timed_out, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_d.size(); i++) begin
      n_cmp++;
      if (got_d[i] !== exp_q[i] || got_l[i] !== (i == exp_q.size() - 1)) begin
        n_err++; $display("FAIL zero_byte%0d: got %h/%0b want %h/%0b", i, got_d[i], got_l[i], exp_q[i], i == exp_q.size() - 1);
      end
    end
  endtask

  task automatic test_max();
    bit ok;
    model(65535, 1'b1);
    send(1'b0, 16'd65535, ok);
    collect(1'b0, 100, 0, 60);
    n_cmp++;
    if (!ok || timed_out || got_d.size() != 7) begin
      n_err++; $display("FAIL max_len: got %0d bytes timeout=%0b want 7", got_d.size(), timed_out);
    end
    for (int i = 0; i < exp_q.size() && i < got_d.size(); i++) begin
      n_cmp++;
      if (got_d[i] !== exp_q[i] || got_l[i] !== (i == exp_q.size() - 1)) begin
        n_err++; $display("FAIL max_byte%0d: got %h/%0b want %h/%0b", i, got_d[i], got_l[i], exp_q[i], i == exp_q.size() - 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    model(1020, 1'b1);
    send(1'b0, 16'd1020, ok);
    valid_a = 1'b1;
    in_data = 16'd7;
    collect(1'b0, 100, 0, 60);
    n_cmp++;
    if (!ok || timed_out || rdy_seen != 0 || ready_a !== 1'b1) begin
      n_err++; $display("FAIL b2b_ready: got early_ready=%0d ready_after_lf=%0b want 0/1", rdy_seen, ready_a);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= got_d.size() || got_d[i] !== exp_q[i] || got_l[i] !== (i == exp_q.size() - 1)) begin
        n_err++; $display("FAIL b2b_first_byte%0d: got %h want %h", i, (i < got_d.size()) ? got_d[i] : 8'hxx, exp_q[i]);
      end
    end
    tick();
    valid_a = 1'b0;
    n_cmp++;
    if (ready_a !== 1'b0) begin
      n_err++; $display("FAIL b2b_accept: got ready=%0b want 0", ready_a);
    end
    model(7, 1'b1);
    collect(1'b0, 100, 0, 60);
    n_cmp++;
    if (timed_out || got_d.size() != exp_q.size()) begin
      n_err++; $display("FAIL b2b_second_len: got %0d want %0d", got_d.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_d.size(); i++) begin
      n_cmp++;
      if (got_d[i] !== exp_q[i] || got_l[i] !== (i == exp_q.size() - 1)) begin
        n_err++; $display("FAIL b2b_second_byte%0d: got %h/%0b want %h", i, got_d[i], got_l[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_stall();
    bit ok;
    model(40961, 1'b1);
    send(1'b0, 16'd40961, ok);
    collect(1'b0, 50, 0, 400);
    n_cmp++;
    if (!ok || timed_out || stall_err != 0 || got_d.size() != exp_q.size()) begin
      n_err++; $display("FAIL stall_line: got %0d bytes unstable=%0d timeout=%0b want %0d/0/0", got_d.size(), stall_err, timed_out, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_d.size(); i++) begin
      n_cmp++;
      if (got_d[i] !== exp_q[i] || got_l[i] !== (i == exp_q.size() - 1)) begin
        n_err++; $display("FAIL stall_byte%0d: got %h/%0b want %h", i, got_d[i], got_l[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    send(1'b0, 16'd12345, ok);
    collect(1'b0, 100, 2, 60);
    reset = 1'b1;
    tick();
    n_cmp++;
    if (!ok || timed_out || ov_a !== 1'b0 || ol_a !== 1'b0 || od_a !== 8'h00 || ready_a !== 1'b0) begin
      n_err++; $display("FAIL midreset_abort: got v=%0b d=%h l=%0b rdy=%0b want 0/00/0/0", ov_a, od_a, ol_a, ready_a);
    end
    reset = 1'b0;
    tick();
    n_cmp++;
    if (ov_a !== 1'b0 || ready_a !== 1'b1) begin
      n_err++; $display("FAIL midreset_idle: got v=%0b rdy=%0b want 0/1", ov_a, ready_a);
    end
    model(9, 1'b1);
    send(1'b0, 16'd9, ok);
    collect(1'b0, 100, 0, 60);
    n_cmp++;
    if (!ok || timed_out || got_d.size() != exp_q.size()) begin
      n_err++; $display("FAIL midreset_next_len: got %0d want %0d", got_d.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_d.size(); i++) begin
      n_cmp++;
      if (got_d[i] !== exp_q[i] || got_l[i] !== (i == exp_q.size() - 1)) begin
        n_err++; $display("FAIL midreset_byte%0d: got %h/%0b want %h", i, got_d[i], got_l[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_lf_only();
    bit ok;
    model(100, 1'b0);
    send(1'b1, 16'd100, ok);
    collect(1'b1, 100, 0, 60);
    n_cmp++;
    if (!ok || timed_out || got_d.size() != 4) begin
      n_err++; $display("FAIL lf_len: got %0d bytes want 4", got_d.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_d.size(); i++) begin
      n_cmp++;
      if (got_d[i] !== exp_q[i] || got_l[i] !== (i == exp_q.size() - 1)) begin
        n_err++; $display("FAIL lf_byte%0d: got %h/%0b want %h", i, got_d[i], got_l[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    bit sel;
    int v;
    for (int t = 0; t < 24; t++) begin
      sel = 1'($urandom_range(1));
      v   = int'($urandom_range(65535) >> $urandom_range(15));
      model(v, !sel);
      send(sel, 16'(v), ok);
      collect(sel, $urandom_range(100, 30), 0, 300);
      n_cmp++;
      if (!ok || timed_out || stall_err != 0 || got_d.size() != exp_q.size()) begin
        n_err++; $display("FAIL rand_line v=%0d: got %0d bytes unstable=%0d want %0d", v, got_d.size(), stall_err, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_d.size(); i++) begin
        n_cmp++;
        if (got_d[i] !== exp_q[i] || got_l[i] !== (i == exp_q.size() - 1)) begin
          n_err++; $display("FAIL rand_byte v=%0d i=%0d: got %h/%0b want %h", v, i, got_d[i], got_l[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_max();
    test_back_to_back();
    test_stall();
    test_mid_reset();
    test_lf_only();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
